// File: rtl/ram_rr_arbiter.sv
// ============================================================================
// Module      : ram_rr_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between
//               NCORES cores, with quantum-limited grants and tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rr_arbiter #(
    parameter int NCORES    = 4,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    wr,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TD = RD_LAT + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          own_q, own_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NCORES-1:0]      gnt_q, gnt_d;
    logic [TD-1:0]          tag_v_q, tag_v_d;
    logic [TD-1:0][PW-1:0]  tag_idx_q, tag_idx_d;
    logic [DW-1:0]          rdata_q, rdata_d;

    logic w_issue;
    logic w_others;
    logic w_last;
    logic w_release;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] k);
        return (int'(k) == NCORES - 1) ? '0 : k + PW'(1);
    endfunction

    // First requester at or after start, wrapping from NCORES-1 to 0.
    function automatic logic [PW-1:0] first_req(input logic [NCORES-1:0] r,
                                                input logic [PW-1:0]     start);
        logic [PW-1:0] idx;
        logic [PW-1:0] win;
        logic          found;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

    assign w_issue   = |(req & gnt_q);
    assign w_others  = |(req & ~gnt_q);
    assign w_last    = (cnt_q == CW'(MAX_BURST - 1));
    assign w_release = (state_q == S_OWN) &&
                       (!req[own_q] || (w_issue && w_last && w_others));

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_OWN;
                    own_d   = first_req(req, ptr_q);
                    cnt_d   = '0;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    ptr_d = next_idx(own_q);
                    cnt_d = '0;
                    if (w_others) begin
                        own_d = first_req(req, next_idx(own_q));
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_issue) begin
                    // Quantum expiry with nobody waiting just restarts the count.
                    cnt_d = w_last ? '0 : cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        gnt_d = (state_d == S_OWN) ? (NCORES'(1) << own_d) : '0;
    end

    always_comb begin
        tag_v_d   = {tag_v_q[TD-2:0], w_issue & ~wr[own_q]};
        tag_idx_d = {tag_idx_q[TD-2:0], own_q};
        rdata_d   = ram_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            own_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            tag_v_q   <= '0;
            tag_idx_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            tag_v_q   <= tag_v_d;
            tag_idx_q <= tag_idx_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt      = gnt_q;
    assign rdata    = rdata_q;
    assign rvalid   = tag_v_q[TD-1] ? (NCORES'(1) << tag_idx_q[TD-1]) : '0;
    assign ram_addr = addr[own_q*AW +: AW];
    assign ram_din  = wdata[own_q*DW +: DW];
    assign ram_wren = w_issue & wr[own_q];

endmodule

`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
// ============================================================================
// Module      : tb_ram_rr_arbiter
// Description : Self-checking bench for ram_rr_arbiter with a behavioural
//               arbitration/RAM reference model and directed vector tables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_rr_arbiter;

    localparam int N         = 4;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wr = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic            ram_wren;
    logic [DW-1:0]   ram_q;

    always #5 clk = ~clk;

    ram_rr_arbiter #(
        .NCORES(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Shared RAM with RD_LAT cycles of read latency.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] qpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        qpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
    end
    assign ram_q = qpipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), pointer, issues in the
    // current grant, and a list of outstanding reads with their due cycle.
    typedef struct {
        int            due;
        int            core;
        logic [DW-1:0] data;
    } ret_t;

    int            m_own = -1;
    int            m_ptr = 0;
    int            m_cnt = 0;
    int            m_cyc = 0;
    logic [DW-1:0] m_mem [256];
    ret_t          rq[$];

    logic [N-1:0]  s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_wren;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_own = -1;
        m_ptr = 0;
        m_cnt = 0;
        rq.delete();
    endtask

    task automatic m_check();
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        bit           issue;
        exp_gnt = (m_own < 0) ? '0 : (N'(1) << m_own);
        issue   = (m_own >= 0) && req[m_own];
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("ram_wren", 32'(ram_wren), 32'(issue && wr[m_own]));
        if (issue) begin
            chk("ram_addr", 32'(ram_addr), 32'(addr[m_own*AW +: AW]));
            if (wr[m_own]) chk("ram_din", 32'(ram_din), 32'(wdata[m_own*DW +: DW]));
        end
        exp_rv = '0;
        if (rq.size() > 0 && rq[0].due == m_cyc) exp_rv = N'(1) << rq[0].core;
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rdata", 32'(rdata), 32'(rq[0].data));
    endtask

    task automatic m_advance();
        int            k;
        bit            issue;
        bit            others;
        logic [AW-1:0] a;
        if (rq.size() > 0 && rq[0].due == m_cyc) void'(rq.pop_front());
        k     = m_own;
        issue = (k >= 0) && req[k];
        if (issue) begin
            a = addr[k*AW +: AW];
            if (wr[k]) m_mem[a] = wdata[k*DW +: DW];
            else       rq.push_back('{m_cyc + RD_LAT + 1, k, m_mem[a]});
        end
        if (k < 0) begin
            if (req != '0) begin
                m_own = pick(req, m_ptr);
                m_cnt = 0;
            end
        end else begin
            others = (req & ~(N'(1) << k)) != '0;
            if (issue) m_cnt++;
            if (!req[k] || (m_cnt == MAX_BURST && others)) begin
                m_ptr = (k + 1) % N;
                m_cnt = 0;
                m_own = others ? pick(req, m_ptr) : -1;
            end else if (m_cnt == MAX_BURST) begin
                m_cnt = 0;
            end
        end
        m_cyc++;
    endtask

    // One clock cycle: inputs are already applied; sample at the falling edge.
    task automatic step();
        @(negedge clk);
        s_gnt    = gnt;
        s_rvalid = rvalid;
        s_rdata  = rdata;
        s_wren   = ram_wren;
        m_check();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_io();
        wr = N'($urandom);
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
            wdata[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic set_all(input logic [N-1:0] r, input logic [N-1:0] w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = r;
        wr  = w;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = a;
            wdata[i*DW +: DW] = d;
        end
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [N-1:0]  gnt;
        logic          wren;
        logic [N-1:0]  rvalid;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl [11];
    int   order [3] = '{0, 1, 3};
    int   issued;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
        #1;
        do_reset();

        // Core2 write/read, then wrap from ptr=3 with cores 0 and 2 requesting.
        //            req      wr       addr   wdata  gnt      wren  rvalid   rdata
        tbl[0]  = '{4'b0100, 4'b0100, 8'h10, 8'h5A, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[1]  = '{4'b0100, 4'b0100, 8'h10, 8'h5A, 4'b0100, 1'b1, 4'b0000, 8'h00};
        tbl[2]  = '{4'b0100, 4'b0000, 8'h10, 8'h00, 4'b0100, 1'b0, 4'b0000, 8'h00};
        tbl[3]  = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0100, 1'b0, 4'b0000, 8'h00};
        tbl[4]  = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b0, 4'b0100, 8'h5A};
        tbl[5]  = '{4'b0101, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[6]  = '{4'b0101, 4'b0000, 8'h10, 8'h00, 4'b0001, 1'b0, 4'b0000, 8'h00};
        tbl[7]  = '{4'b0100, 4'b0000, 8'h10, 8'h00, 4'b0001, 1'b0, 4'b0000, 8'h00};
        tbl[8]  = '{4'b0100, 4'b0000, 8'h10, 8'h00, 4'b0100, 1'b0, 4'b0001, 8'h5A};
        tbl[9]  = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0100, 1'b0, 4'b0000, 8'h00};
        tbl[10] = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b0, 4'b0100, 8'h5A};
        for (int i = 0; i < 11; i++) begin
            set_all(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            step();
            chk("tbl_gnt", 32'(s_gnt), 32'(tbl[i].gnt));
            chk("tbl_wren", 32'(s_wren), 32'(tbl[i].wren));
            chk("tbl_rvalid", 32'(s_rvalid), 32'(tbl[i].rvalid));
            if (tbl[i].rvalid != '0) chk("tbl_rdata", 32'(s_rdata), 32'(tbl[i].rdata));
        end

        // Contention: cores 0,1,3 from reset, 8 issues each, back-to-back.
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            req = 4'b1011;
            rand_io();
            step();
            chk("contention_gnt", 32'(s_gnt),
                (c == 0) ? 32'd0 : (32'd1 << order[((c - 1) / MAX_BURST) % 3]));
        end
        req = '0;
        repeat (3) step();

        // Quantum with no contention: core1 keeps the grant for 20 accesses.
        do_reset();
        issued = 0;
        for (int c = 0; c <= 20; c++) begin
            req = 4'b0010;
            rand_io();
            step();
            chk("quantum_gnt", 32'(s_gnt), (c == 0) ? 32'd0 : 32'b0010);
            if (s_gnt[1]) issued++;
        end
        chk("quantum_issues", 32'(issued), 32'd20);
        req = '0;
        repeat (3) step();

        // Reset mid-burst with a read in flight; ptr must restart at 0.
        set_all(4'b0010, 4'b0000, 8'h05, 8'h00);
        step();
        step();
        req = '0;
        do_reset();
        for (int i = 0; i < RD_LAT + 2; i++) begin
            step();
            chk("reset_rvalid", 32'(s_rvalid), 32'd0);
        end
        req = 4'b1010;
        step();
        step();
        chk("reset_ptr", 32'(s_gnt), 32'b0010);
        req = '0;
        repeat (3) step();

        // Early drop: core0 drops after 3 accesses while core2 waits.
        do_reset();
        set_all(4'b0101, 4'b0000, 8'h30, 8'h00);
        step();
        wr = 4'b0001; addr[7:0] = 8'h20; wdata[7:0] = 8'h77;
        step();
        addr[7:0] = 8'h21; wdata[7:0] = 8'h11;
        step();
        wr = 4'b0000; addr[7:0] = 8'h20;
        step();
        req = 4'b0100;
        step();
        chk("drop_gnt_hold", 32'(s_gnt), 32'b0001);
        step();
        chk("drop_gnt_move", 32'(s_gnt), 32'b0100);
        chk("drop_rvalid", 32'(s_rvalid), 32'b0001);
        chk("drop_rdata", 32'(s_rdata), 32'h77);
        req = '0;
        repeat (3) step();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            rand_io();
            if (c == 1500) do_reset();
            step();
        end
        req = '0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
